// File: rtl/serial_add_pkg.sv
// Shared state type and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bit counter only needs to reach WIDTH-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  logic             sub;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/full_add_cell.sv
// One-bit full adder made of two half adders with their carries ORed.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_add u_ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
  half_add u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_add.sv
// One-bit half adder, the building block of full_add_cell.
module half_add (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_add_cell, LSB first, registered carry.
// Define SERIAL_ADD_SUB_EN to add the subtract select (b inverted, carry-in 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_c;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

  full_add_cell u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (cell_s),
    .cout(cell_c)
  );

  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: a + ~b + 1; final carry is the no-borrow flag.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_init = bus.sub;
`else
  assign b_load     = bus.b;
  assign carry_init = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so the LSB-first result lands in place after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= b_load;
      sum_r <= '0;
      carry <= carry_init;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum_r <= {cell_s, sum_r[WIDTH-1:1]};
      carry <= cell_c;
      if (last_bit) cout_r <= cell_c;
      else          cnt    <= cnt + CW'(1);
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule
